grf_wb_arbiter: RTL and testbench
=================================

GRF_WB_ARBITER -- requirements
Module: grf_wb_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with requester 0 winning.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset; sampled on rising clk edge while 0.
REQ-004 Port: req0_valid  input  1  requester 0 holds a write-back.
REQ-005 Port: req0_reg  input  5  requester 0 destination register.
REQ-006 Port: req0_data  input  32  requester 0 write data.
REQ-007 Port: req0_pc  input  32  requester 0 instruction PC, for the write log.
REQ-008 Port: req0_ready  output  1  requester 0 is granted this cycle (combinational).
REQ-009 Port: req1_valid, req1_reg, req1_data, req1_pc, req1_ready  same widths  requester 1, same meanings as requester 0.
REQ-010 Port: issue_valid  input  1  an instruction with a GRF destination is issued this cycle.
REQ-011 Port: issue_reg  input  5  destination register of the issued instruction.
REQ-012 Port: query1_reg, query2_reg  input  5 each  source registers checked for pending writes.
REQ-013 Port: busy1, busy2  output  1 each  the queried register has a pending, uncommitted write (combinational).
REQ-014 Port: grf_wen, grf_wreg[4:0], grf_wd[31:0], grf_wpc[31:0]  output  GRF write port, all registered.

Function
REQ-015 Handshake: a transfer occurs on a rising edge where reqN_valid=1 and reqN_ready=1; requesters hold valid, reg, data and pc stable until the transfer.
REQ-016 At most one ready is high per cycle; ready is never high without the matching valid.
REQ-017 Only one requester valid: it is granted in the same cycle, regardless of the priority pointer.
REQ-018 Both requesters valid with RR_EN=1: the requester selected by the 1-bit pointer is granted, and the pointer then moves to the other requester.
REQ-019 Pointer: it changes only on a grant that happens while both requesters are valid; it is 0 (requester 0) after reset.
REQ-020 Both requesters valid with RR_EN=0: requester 0 is always granted, and the pointer is unused.
REQ-021 Latency: one cycle. On the edge after a transfer, grf_wen=1 and grf_wreg, grf_wd and grf_wpc equal the granted request.
REQ-022 With no transfer, grf_wen=0 on the next cycle, and grf_wreg, grf_wd and grf_wpc hold their last values.
REQ-023 Throughput: one write per cycle with no bubble between back-to-back grants.
REQ-024 Writes to register 0: the transfer is accepted (ready=1), but grf_wen stays 0 for that slot.
REQ-025 Scoreboard: a 32-bit pending vector; issue_valid=1 with issue_reg!=0 sets bit issue_reg on the edge.
REQ-026 Commit: a transfer with reg R != 0 clears bit R on the same edge as the transfer, not when grf_wen rises.
REQ-027 Simultaneous set and clear of the same bit: set wins, because a newer producer is outstanding.
REQ-028 Simultaneous set and clear of different bits: both take effect.
REQ-029 busyK = pending[queryK_reg], with no bypass of same-cycle sets or clears; register 0 always reads busy=0.
REQ-030 A transfer for a register whose bit is already 0 is legal; the bit stays 0.

Reset
REQ-031 On reset=0 at an edge, the following are cleared: grf_wen=0, grf_wreg=0, grf_wd=0, grf_wpc=0, pending vector all 0, pointer 0.
REQ-032 While reset=0, req0_ready and req1_ready are 0, and busy1 and busy2 are 0.
REQ-033 Reset mid-operation: a transfer accepted on the edge before reset is discarded if not yet driven, and no grf_wen pulse appears for it after reset.
REQ-034 Reset applied in the same cycle as valid, issue or transfer inputs: those inputs are ignored for that edge.

Verification
REQ-035 Single requester: req0 (reg=5, data=0x1234, pc=0x3000) → req0_ready=1 in the same cycle; next cycle grf_wen=1, grf_wreg=5, grf_wd=0x1234, grf_wpc=0x3000.
REQ-036 Contention, RR_EN=1: both valid for 4 cycles → grants alternate 0,1,0,1; grf_wen=1 in 4 consecutive cycles.
REQ-037 Contention, RR_EN=0: both valid for 3 cycles → req0 granted all 3 cycles; req1_ready stays 0.
REQ-038 Scoreboard: issue reg 8, then query1_reg=8 → busy1=1; req1 commits reg 8 → busy1=0 on the cycle after the transfer; same-edge issue and commit of reg 8 → busy stays 1.
REQ-039 Register 0: req0 with reg=0 → ready=1 and grf_wen stays 0; issue reg 0 → query of reg 0 gives busy=0.
REQ-040 Reset: transfer accepted, then reset=0 on the next edge → no grf_wen pulse; pending vector all 0; pointer 0.

Source files
------------

// File: rtl/grf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// grf_wb_arbiter
//
// This block merges two write-back requesters onto a single GRF write port. It
// also keeps a pending-write scoreboard so that issue logic can detect RAW
// hazards on source registers.
//
// Ports
//   clk                  rising-edge clock
//   reset                synchronous, active-low reset
//   req0_* / req1_*      valid/ready write-back requesters (reg, data, pc)
//   req0/1_ready         grant for the current cycle (combinational)
//   issue_valid/_reg     issued instruction with a GRF destination
//   query1/2_reg         source registers to check for pending writes
//   busy1/2              the queried register has an uncommitted write (comb)
//   grf_wen/wreg/wd/wpc  registered GRF write port, one cycle after transfer
//
// Parameters
//   RR_EN                1: round-robin on contention, 0: requester 0 wins
// -----------------------------------------------------------------------------
module grf_wb_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [4:0]  req0_reg,
  input  logic [31:0] req0_data,
  input  logic [31:0] req0_pc,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_reg,
  input  logic [31:0] req1_data,
  input  logic [31:0] req1_pc,
  output logic        req1_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_reg,
  input  logic [4:0]  query1_reg,
  input  logic [4:0]  query2_reg,
  output logic        busy1,
  output logic        busy2,
  output logic        grf_wen,
  output logic [4:0]  grf_wreg,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_wpc
);

  // One-hot decode of a register index; register 0 never produces a bit.
  function automatic logic [31:0] reg_onehot(input logic [4:0] r);
    logic [31:0] v;
    if (r == 5'd0) begin
      v = 32'h0000_0000;
    end else begin
      v = 32'h0000_0001 << r;
    end
    return v;
  endfunction

  logic        ptr_r;
  logic [31:0] pending_r;
  logic        wen_r;
  logic [4:0]  wreg_r;
  logic [31:0] wd_r;
  logic [31:0] wpc_r;

  logic        both_s;
  logic        grant0_s;
  logic        grant1_s;
  logic        xfer_s;
  logic        write_s;
  logic [4:0]  sel_reg_s;
  logic [31:0] sel_data_s;
  logic [31:0] sel_pc_s;
  logic [31:0] set_vec_s;
  logic [31:0] clr_vec_s;
  logic [31:0] pending_next_s;
  logic        busy1_s;
  logic        busy2_s;

  // Grant selection: a lone requester always wins; contention uses the pointer
  // in round-robin mode and requester 0 otherwise. Nothing is granted in reset.
  always_comb begin
    both_s   = req0_valid & req1_valid;
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!reset) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (both_s) begin
      if ((RR_EN != 0) && ptr_r) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b1;
      end
    end else if (req0_valid) begin
      grant0_s = 1'b1;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Mux the granted request onto the write path.
  always_comb begin
    xfer_s = grant0_s | grant1_s;
    if (grant1_s) begin
      sel_reg_s  = req1_reg;
      sel_data_s = req1_data;
      sel_pc_s   = req1_pc;
    end else begin
      sel_reg_s  = req0_reg;
      sel_data_s = req0_data;
      sel_pc_s   = req0_pc;
    end
    // Writes to register 0 are accepted but never reach the GRF.
    write_s = xfer_s && (sel_reg_s != 5'd0);
  end

  // Scoreboard next state: the clear is applied first and the set second, so a
  // newer producer of the same register keeps the bit set.
  always_comb begin
    if (reset && issue_valid) begin
      set_vec_s = reg_onehot(issue_reg);
    end else begin
      set_vec_s = 32'h0000_0000;
    end
    if (write_s) begin
      clr_vec_s = reg_onehot(sel_reg_s);
    end else begin
      clr_vec_s = 32'h0000_0000;
    end
    pending_next_s = (pending_r & ~clr_vec_s) | set_vec_s;
  end

  // Hazard lookup from registered state only; same-cycle sets and clears are
  // deliberately not bypassed.
  always_comb begin
    if (!reset) begin
      busy1_s = 1'b0;
      busy2_s = 1'b0;
    end else begin
      busy1_s = (query1_reg != 5'd0) && pending_r[query1_reg];
      busy2_s = (query2_reg != 5'd0) && pending_r[query2_reg];
    end
  end

  // State update: pointer, scoreboard and registered write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_r     <= 1'b0;
      pending_r <= 32'h0000_0000;
      wen_r     <= 1'b0;
      wreg_r    <= 5'd0;
      wd_r      <= 32'h0000_0000;
      wpc_r     <= 32'h0000_0000;
    end else begin
      // Under contention a grant always happens, so the pointer flips.
      if ((RR_EN != 0) && both_s) begin
        ptr_r <= ~ptr_r;
      end
      pending_r <= pending_next_s & 32'hFFFF_FFFE;
      wen_r     <= write_s;
      // The port fields only move on a real write and hold otherwise.
      if (write_s) begin
        wreg_r <= sel_reg_s;
        wd_r   <= sel_data_s;
        wpc_r  <= sel_pc_s;
      end
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign busy1      = busy1_s;
  assign busy2      = busy2_s;
  assign grf_wen    = wen_r;
  assign grf_wreg   = wreg_r;
  assign grf_wd     = wd_r;
  assign grf_wpc    = wpc_r;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_grf_wb_arbiter
//
// This bench drives a round-robin instance (index 0) and a fixed-priority
// instance (index 1) from shared inputs. Both are checked against a behavioural
// model that holds a pending-register set, a priority pointer and the expected
// write port. A directed vector table checks the round-robin instance against
// hand-derived values, and a short hand sequence checks fixed-priority
// contention. Randomised traffic follows.
// -----------------------------------------------------------------------------
module tb_grf_wb_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v0, v1, iv;
  logic [4:0]  rg0, rg1, ir, q1, q2;
  logic [31:0] d0, d1, pc0, pc1;

  logic [1:0]  rdy0_o, rdy1_o, bz1_o, bz2_o, wen_o;
  logic [4:0]  wreg_o [2];
  logic [31:0] wd_o   [2];
  logic [31:0] wpc_o  [2];

  grf_wb_arbiter #(.RR_EN(1)) u_rr (
    .clk(clk), .reset(rst),
    .req0_valid(v0), .req0_reg(rg0), .req0_data(d0), .req0_pc(pc0), .req0_ready(rdy0_o[0]),
    .req1_valid(v1), .req1_reg(rg1), .req1_data(d1), .req1_pc(pc1), .req1_ready(rdy1_o[0]),
    .issue_valid(iv), .issue_reg(ir), .query1_reg(q1), .query2_reg(q2),
    .busy1(bz1_o[0]), .busy2(bz2_o[0]),
    .grf_wen(wen_o[0]), .grf_wreg(wreg_o[0]), .grf_wd(wd_o[0]), .grf_wpc(wpc_o[0])
  );

  grf_wb_arbiter #(.RR_EN(0)) u_fp (
    .clk(clk), .reset(rst),
    .req0_valid(v0), .req0_reg(rg0), .req0_data(d0), .req0_pc(pc0), .req0_ready(rdy0_o[1]),
    .req1_valid(v1), .req1_reg(rg1), .req1_data(d1), .req1_pc(pc1), .req1_ready(rdy1_o[1]),
    .issue_valid(iv), .issue_reg(ir), .query1_reg(q1), .query2_reg(q2),
    .busy1(bz1_o[1]), .busy2(bz2_o[1]),
    .grf_wen(wen_o[1]), .grf_wreg(wreg_o[1]), .grf_wd(wd_o[1]), .grf_wpc(wpc_o[1])
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model state, one copy per instance (0 = round-robin).
  bit          m_pend [2][32];
  int          m_ptr  [2];
  logic        m_wen  [2];
  logic [4:0]  m_wreg [2];
  logic [31:0] m_wd   [2];
  logic [31:0] m_wpc  [2];
  int          last_winner [2];   // -1 none, otherwise requester index

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Which requester wins this cycle: -1 none, 0 or 1.
  function automatic int winner(input int m);
    if (!rst) return -1;
    if (v0 && v1) begin
      if (m == 0) return m_ptr[0];
      return 0;
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic logic busy_of(input int m, input logic [4:0] q);
    if (!rst || q == 5'd0) return 1'b0;
    return logic'(m_pend[m][q]);
  endfunction

  task automatic check_comb();
    for (int m = 0; m < 2; m++) begin
      int w;
      w = winner(m);
      chk($sformatf("ready0[%0d]", m), 32'(rdy0_o[m]), 32'(w == 0));
      chk($sformatf("ready1[%0d]", m), 32'(rdy1_o[m]), 32'(w == 1));
      chk($sformatf("busy1[%0d]", m), 32'(bz1_o[m]), 32'(busy_of(m, q1)));
      chk($sformatf("busy2[%0d]", m), 32'(bz2_o[m]), 32'(busy_of(m, q2)));
    end
  endtask

  task automatic update_model();
    for (int m = 0; m < 2; m++) begin
      int w;
      logic [4:0] r;
      w = winner(m);
      last_winner[m] = w;
      if (!rst) begin
        for (int b = 0; b < 32; b++) m_pend[m][b] = 1'b0;
        m_ptr[m] = 0;
        m_wen[m] = 1'b0;
        m_wreg[m] = 5'd0;
        m_wd[m] = 32'h0;
        m_wpc[m] = 32'h0;
      end else begin
        r = (w == 1) ? rg1 : rg0;
        if (w >= 0 && r != 5'd0) begin
          m_wen[m]  = 1'b1;
          m_wreg[m] = r;
          m_wd[m]   = (w == 1) ? d1 : d0;
          m_wpc[m]  = (w == 1) ? pc1 : pc0;
          m_pend[m][r] = 1'b0;
        end else begin
          m_wen[m] = 1'b0;
        end
        // A newer issue is applied after the commit and therefore wins.
        if (iv && ir != 5'd0) m_pend[m][ir] = 1'b1;
        if (m == 0 && v0 && v1) m_ptr[0] = 1 - m_ptr[0];
      end
    end
  endtask

  task automatic check_regs();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("wen[%0d]", m),  32'(wen_o[m]),  32'(m_wen[m]));
      chk($sformatf("wreg[%0d]", m), 32'(wreg_o[m]), 32'(m_wreg[m]));
      chk($sformatf("wd[%0d]", m),   wd_o[m],  m_wd[m]);
      chk($sformatf("wpc[%0d]", m),  wpc_o[m], m_wpc[m]);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_comb();
    @(posedge clk);
    update_model();
    #1;
    check_regs();
  endtask

  typedef struct {
    logic        rst;
    logic        v0;  logic [4:0] rg0; logic [31:0] d0; logic [31:0] pc0;
    logic        v1;  logic [4:0] rg1; logic [31:0] d1; logic [31:0] pc1;
    logic        iv;  logic [4:0] ir;  logic [4:0]  q1; logic [4:0]  q2;
    logic        e_rdy0; logic e_rdy1; logic e_busy1; logic e_wen; logic [4:0] e_wreg;
  } vec_t;

  vec_t vec [16];

  initial begin
    // rst v0 rg0 d0 pc0 | v1 rg1 d1 pc1 | iv ir q1 q2 | rdy0 rdy1 busy1 wen wreg (RR instance)
    vec[0]  = '{1'b0, 1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0,  32'h0,  32'h0,    1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vec[1]  = '{1'b0, 1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0, 5'd0,  32'h0,  32'h0,    1'b1, 5'd8,  5'd8,  5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vec[2]  = '{1'b1, 1'b1, 5'd5, 32'h1234, 32'h3000, 1'b0, 5'd0,  32'h0,  32'h0,    1'b1, 5'd8,  5'd8,  5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5};
    vec[3]  = '{1'b1, 1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0,  32'h0,  32'h0,    1'b0, 5'd0,  5'd8,  5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5};
    vec[4]  = '{1'b1, 1'b1, 5'd3, 32'hA3,   32'h3004, 1'b1, 5'd8,  32'hB8, 32'h4000, 1'b0, 5'd0,  5'd8,  5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3};
    vec[5]  = '{1'b1, 1'b1, 5'd4, 32'hA4,   32'h3008, 1'b1, 5'd8,  32'hB8, 32'h4000, 1'b0, 5'd0,  5'd8,  5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8};
    vec[6]  = '{1'b1, 1'b1, 5'd4, 32'hA4,   32'h3008, 1'b1, 5'd9,  32'hB9, 32'h4004, 1'b0, 5'd0,  5'd8,  5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4};
    vec[7]  = '{1'b1, 1'b1, 5'd6, 32'hA6,   32'h300C, 1'b1, 5'd9,  32'hB9, 32'h4004, 1'b0, 5'd0,  5'd8,  5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd9};
    vec[8]  = '{1'b1, 1'b0, 5'd0, 32'h0,    32'h0,    1'b1, 5'd8,  32'hC8, 32'h4008, 1'b1, 5'd8,  5'd8,  5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd8};
    vec[9]  = '{1'b1, 1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0,  32'h0,  32'h0,    1'b0, 5'd0,  5'd8,  5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8};
    vec[10] = '{1'b1, 1'b1, 5'd0, 32'hDEAD, 32'h5000, 1'b0, 5'd0,  32'h0,  32'h0,    1'b1, 5'd0,  5'd0,  5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8};
    vec[11] = '{1'b1, 1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0,  32'h0,  32'h0,    1'b0, 5'd0,  5'd0,  5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8};
    vec[12] = '{1'b1, 1'b1, 5'd7, 32'hA7,   32'h3010, 1'b1, 5'd11, 32'hBB, 32'h400C, 1'b1, 5'd10, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7};
    vec[13] = '{1'b0, 1'b1, 5'd2, 32'hA2,   32'h3014, 1'b1, 5'd11, 32'hBB, 32'h400C, 1'b1, 5'd12, 5'd10, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vec[14] = '{1'b1, 1'b1, 5'd2, 32'hA2,   32'h3014, 1'b1, 5'd11, 32'hBB, 32'h400C, 1'b0, 5'd0,  5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2};
    vec[15] = '{1'b1, 1'b0, 5'd0, 32'h0,    32'h0,    1'b0, 5'd0,  32'h0,  32'h0,    1'b0, 5'd0,  5'd10, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2};

    rst = 1'b0; v0 = 1'b0; v1 = 1'b0; iv = 1'b0;
    rg0 = 5'd0; rg1 = 5'd0; ir = 5'd0; q1 = 5'd0; q2 = 5'd0;
    d0 = 32'h0; d1 = 32'h0; pc0 = 32'h0; pc1 = 32'h0;
    @(posedge clk);
    update_model();
    #1;

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      rst = vec[i].rst;
      v0 = vec[i].v0; rg0 = vec[i].rg0; d0 = vec[i].d0; pc0 = vec[i].pc0;
      v1 = vec[i].v1; rg1 = vec[i].rg1; d1 = vec[i].d1; pc1 = vec[i].pc1;
      iv = vec[i].iv; ir = vec[i].ir; q1 = vec[i].q1; q2 = vec[i].q2;
      @(negedge clk);
      check_comb();
      chk($sformatf("vec%0d ready0", i), 32'(rdy0_o[0]), 32'(vec[i].e_rdy0));
      chk($sformatf("vec%0d ready1", i), 32'(rdy1_o[0]), 32'(vec[i].e_rdy1));
      chk($sformatf("vec%0d busy1", i),  32'(bz1_o[0]),  32'(vec[i].e_busy1));
      @(posedge clk);
      update_model();
      #1;
      check_regs();
      chk($sformatf("vec%0d wen", i),  32'(wen_o[0]),  32'(vec[i].e_wen));
      chk($sformatf("vec%0d wreg", i), 32'(wreg_o[0]), 32'(vec[i].e_wreg));
    end

    // Fixed-priority contention: requester 0 wins three cycles in a row.
    rst = 1'b1; iv = 1'b0; q1 = 5'd0; q2 = 5'd0;
    v1 = 1'b1; rg1 = 5'd13; d1 = 32'hF13; pc1 = 32'h6000;
    for (int k = 0; k < 3; k++) begin
      v0 = 1'b1; rg0 = 5'(20 + k); d0 = 32'hE00 + 32'(k); pc0 = 32'h7000 + 32'(4 * k);
      @(negedge clk);
      check_comb();
      chk($sformatf("fp%0d ready0", k), 32'(rdy0_o[1]), 32'h1);
      chk($sformatf("fp%0d ready1", k), 32'(rdy1_o[1]), 32'h0);
      @(posedge clk);
      update_model();
      #1;
      check_regs();
      chk($sformatf("fp%0d wen", k),  32'(wen_o[1]),  32'h1);
      chk($sformatf("fp%0d wreg", k), 32'(wreg_o[1]), 32'(20 + k));
    end

    // Randomised traffic; requesters hold their request until the round-robin
    // instance grants it.
    v0 = 1'b0; v1 = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!v0 || last_winner[0] == 0) begin
        v0  = ($urandom_range(0, 9) < 6);
        rg0 = 5'($urandom_range(0, 7));
        d0  = $urandom;
        pc0 = $urandom;
      end
      if (!v1 || last_winner[0] == 1) begin
        v1  = ($urandom_range(0, 9) < 6);
        rg1 = 5'($urandom_range(0, 7));
        d1  = $urandom;
        pc1 = $urandom;
      end
      iv  = ($urandom_range(0, 1) == 1);
      ir  = 5'($urandom_range(0, 7));
      q1  = 5'($urandom_range(0, 7));
      q2  = 5'($urandom_range(0, 7));
      rst = ($urandom_range(0, 39) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
